// File: rtl/piso_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : piso_serializer                                               |
// | Purpose  : Parallel-in/serial-out transmitter with valid/ready load.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module piso_serializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             d_out,
   output logic             d_valid,
   output logic             busy,
   output logic             done
);

   localparam int             CW     = $clog2(WIDTH);
   localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dout_q, dout_d;
   logic             done_q, done_d;
   logic             w_accept;
   logic             w_last;

   assign w_last     = (state_q == S_SHIFT) && (cnt_q == C_LAST);
   assign load_ready = Reset && ((state_q == S_IDLE) || w_last);
   assign w_accept   = load_valid && load_ready;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      dout_d  = 1'b0;
      if (w_accept) begin
         // The first bit goes straight into the output flop; the shift
         // register keeps the whole word and is advanced on later bits.
         state_d = S_SHIFT;
         cnt_d   = '0;
         shreg_d = data_in;
         dout_d  = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
      end else if (state_q == S_SHIFT) begin
         if (w_last) begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
            if (MSB_FIRST) begin
               shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
               dout_d  = shreg_q[WIDTH-2];
            end else begin
               shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
               dout_d  = shreg_q[1];
            end
         end
      end
      done_d = (state_d == S_SHIFT) && (cnt_d == C_LAST);
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         dout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
      end
   end

   assign d_out   = dout_q;
   assign d_valid = (state_q == S_SHIFT);
   assign busy    = (state_q == S_SHIFT);
   assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_piso_serializer                                            |
// | Purpose  : Bit-queue reference model plus SIPO receiver for two configs. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_piso_serializer;

   logic       clk;
   logic       rst_n;
   logic       lv0, lv1;
   logic [3:0] d0;
   logic [7:0] d1;
   logic       rdy0, rdy1, do0, do1, dv0, dv1, bz0, bz1, dn0, dn1;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: a list of bits still to be shown, plus the bit on the wire.
   int fb   [2][0:15];
   int fl   [2][0:15];
   int hd   [2];
   int tl   [2];
   int cur_b[2];
   int cur_v[2];
   int cur_l[2];
   int wif  [2];
   int asm_w[2];
   int aidx [2];
   bit acc  [2];

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut4 (
      .Clock(clk), .Reset(rst_n), .data_in(d0), .load_valid(lv0),
      .load_ready(rdy0), .d_out(do0), .d_valid(dv0), .busy(bz0), .done(dn0)
   );

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut8 (
      .Clock(clk), .Reset(rst_n), .data_in(d1), .load_valid(lv1),
      .load_ready(rdy1), .d_out(do1), .d_valid(dv1), .busy(bz1), .done(dn1)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: check load_ready before the edge, advance model, check outputs.
   task automatic step();
      int wd[2];
      #1;
      for (int k = 0; k < 2; k++) begin
         int exp_rdy = (rst_n && (tl[k] - hd[k] == 0)) ? 1 : 0;
         chk(k ? "load_ready8" : "load_ready4", k ? int'(rdy1) : int'(rdy0), exp_rdy);
         acc[k] = (exp_rdy == 1) && (k ? lv1 : lv0);
         wd[k]  = k ? int'(d1) : int'(d0);
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         int w   = k ? 8 : 4;
         bit msb = (k == 0);
         int o_do = k ? int'(do1) : int'(do0);
         int o_dv = k ? int'(dv1) : int'(dv0);
         int o_bz = k ? int'(bz1) : int'(bz0);
         int o_dn = k ? int'(dn1) : int'(dn0);
         if (!rst_n) begin
            hd[k] = 0; tl[k] = 0;
            cur_b[k] = 0; cur_v[k] = 0; cur_l[k] = 0;
            asm_w[k] = 0; aidx[k] = 0;
         end else begin
            if (acc[k]) begin
               for (int i = 0; i < w; i++) begin
                  int bi = msb ? (w - 1 - i) : i;
                  fb[k][i] = (wd[k] >> bi) & 1;
                  fl[k][i] = (i == w - 1) ? 1 : 0;
               end
               hd[k] = 0; tl[k] = w; wif[k] = wd[k];
            end
            if (hd[k] < tl[k]) begin
               cur_b[k] = fb[k][hd[k]]; cur_l[k] = fl[k][hd[k]]; cur_v[k] = 1;
               hd[k]++;
            end else begin
               cur_b[k] = 0; cur_l[k] = 0; cur_v[k] = 0;
            end
         end
         chk(k ? "d_out8"   : "d_out4",   o_do, cur_b[k]);
         chk(k ? "d_valid8" : "d_valid4", o_dv, cur_v[k]);
         chk(k ? "busy8"    : "busy4",    o_bz, cur_v[k]);
         chk(k ? "done8"    : "done4",    o_dn, cur_v[k] & cur_l[k]);
         if (rst_n && o_dv == 1) begin
            if (msb) asm_w[k] = ((asm_w[k] << 1) | o_do) & ((1 << w) - 1);
            else     asm_w[k] = asm_w[k] | (o_do << aidx[k]);
            aidx[k]++;
         end
         if (rst_n && o_dn == 1) begin
            chk(k ? "sipo_word8" : "sipo_word4", asm_w[k], wif[k]);
            chk(k ? "sipo_len8"  : "sipo_len4",  aidx[k],  w);
            asm_w[k] = 0; aidx[k] = 0;
         end
      end
   endtask

   task automatic send(input int k, input int word);
      int n = 0;
      if (k == 0) begin d0 = 4'(word); lv0 = 1'b1; end
      else        begin d1 = 8'(word); lv1 = 1'b1; end
      acc[k] = 1'b0;
      while (!acc[k] && n < 12) begin
         step();
         n++;
      end
      chk(k ? "accept_timeout8" : "accept_timeout4", int'(acc[k]), 1);
      if (k == 0) lv0 = 1'b0;
      else        lv1 = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         hd[k] = 0; tl[k] = 0; cur_b[k] = 0; cur_v[k] = 0; cur_l[k] = 0;
         wif[k] = 0; asm_w[k] = 0; aidx[k] = 0; acc[k] = 1'b0;
      end
      rst_n = 1'b0; lv0 = 1'b1; lv1 = 1'b1; d0 = 4'hF; d1 = 8'hFF;
      // Reset held with a word offered: nothing may be accepted.
      step();
      step();
      rst_n = 1'b1; lv0 = 1'b0; lv1 = 1'b0;
      step();

      send(0, 4'b1011);
      repeat (5) step();

      send(0, 4'b1011);
      send(0, 4'b0110);
      repeat (5) step();

      send(0, 4'b0000);
      send(0, 4'b1111);
      repeat (5) step();

      send(0, 4'b1100);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      send(0, 4'b0011);
      repeat (5) step();

      send(1, 8'hA5);
      repeat (9) step();

      for (int c = 0; c < 600; c++) begin
         rst_n = ($urandom_range(0, 79) != 0);
         lv0   = ($urandom_range(0, 3) != 0);
         lv1   = ($urandom_range(0, 3) != 0);
         d0    = 4'($urandom);
         d1    = 8'($urandom);
         step();
      end
      rst_n = 1'b1; lv0 = 1'b0; lv1 = 1'b0;
      repeat (10) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
